// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the writeback request bundle.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_bypass.sv
// Two-port forward mux: serves the in-flight regfile write to both read ports.
module wb_bypass #(
  parameter int unsigned XLEN = cpu_pkg::XLEN,
  parameter int unsigned AW   = cpu_pkg::AW
) (
  input  logic            w_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] w_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);
  import cpu_pkg::*;

  logic hit1, hit2;

  // x0 never forwards: it must always read the hardwired regfile value.
  assign hit1 = w_en && (rd_addr == rs1_addr) && (rs1_addr != AW'(REG_ZERO));
  assign hit2 = w_en && (rd_addr == rs2_addr) && (rs2_addr != AW'(REG_ZERO));

  assign rs1_data = hit1 ? w_data : rf_rs1_data;
  assign rs2_data = hit2 ? w_data : rf_rs2_data;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: L-priority with anti-starvation for A, registered
// regfile write port, and read-port bypass of the in-flight write.
module wb_arbiter #(
  parameter int unsigned XLEN       = cpu_pkg::XLEN,
  parameter int unsigned AW         = cpu_pkg::AW,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            l_valid,
  input  logic [AW-1:0]   l_rd,
  input  logic [XLEN-1:0] l_data,
  output logic            l_ready,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] w_data,
  output logic            w_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [3:0]      a_wait_cnt
);
  import cpu_pkg::*;

  logic [3:0]      cnt, cnt_next;
  logic            grant_a, grant_l, win_we;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  always_comb begin
    grant_a  = a_valid && (!l_valid || (cnt >= 4'(STARVE_MAX)));
    grant_l  = l_valid && !grant_a;
    win_rd   = grant_a ? a_rd   : l_rd;
    win_data = grant_a ? a_data : l_data;
    // x0 writes are accepted from the source but never reach the regfile.
    win_we   = (grant_a || grant_l) && (win_rd != AW'(REG_ZERO));
    cnt_next = '0;
    if (a_valid && l_valid && !grant_a)
      cnt_next = (cnt == '1) ? cnt : cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      w_en    <= 1'b0;
      rd_addr <= '0;
      w_data  <= '0;
    end else begin
      cnt  <= cnt_next;
      w_en <= win_we;
      if (win_we) begin
        rd_addr <= win_rd;
        w_data  <= win_data;
      end
    end
  end

  assign a_ready    = grant_a;
  assign l_ready    = grant_l;
  assign a_wait_cnt = cnt;

  wb_bypass #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_bypass (
    .w_en        (w_en),
    .rd_addr     (rd_addr),
    .w_data      (w_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data)
  );

endmodule
